// File: rtl/stat_pkg.sv
// -----------------------------------------------------------------------------
// stat_pkg
//  Shared constants for the score/health/high-score producer block.
//  - ST_IDLE / ST_PLAY / ST_OVER : game FSM encoding, also seen on the state port
//  - K_SCORE / K_DAMAGE / K_START : bit positions of the buttons within key_n
//  - sat_inc8                     : 8-bit increment that sticks at 8'hFF
// -----------------------------------------------------------------------------
package stat_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam int K_SCORE  = 0;
    localparam int K_DAMAGE = 1;
    localparam int K_START  = 2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//  Synchronises one raw active-low button, filters it and emits a one-cycle
//  press pulse on each debounced 1->0 transition (releases make no event).
//  Ports:
//   clk     in  1  system clock
//   resetn  in  1  synchronous, active-low reset
//   key_n   in  1  raw button, active low, asynchronous to clk
//   press   out 1  one-cycle pulse per debounced press
// -----------------------------------------------------------------------------
module key_debounce
    import stat_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // The synchroniser flops reset to the released level so that leaving reset
    // never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == stable) begin
                // Any bounce back to the stable level restarts the qualification.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= s2;
                cnt    <= '0;
                // s2 == 0 here means the accepted flip is released -> pressed.
                press  <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stat_event_ctrl.sv
// -----------------------------------------------------------------------------
// stat_event_ctrl
//  Producer side of the score / health / high-score displays. Debounces the
//  three game buttons, runs the IDLE/PLAY/OVER game FSM and holds the binary
//  score, all-time-best and health registers decoded by the hex displays.
//  Ports:
//   clk        in  1  system clock
//   resetn     in  1  synchronous, active-low reset
//   key_n      in  3  raw buttons, active low: [0] score, [1] damage, [2] start
//   score      out 8  current score
//   all_time   out 8  best score since reset
//   health     out 8  remaining health
//   game_over  out 1  high while in OVER
//   over_pulse out 1  one-cycle pulse on entry to OVER
//   state      out 2  FSM state (IDLE=0, PLAY=1, OVER=2)
//  Every output is a flop; key_n only reaches them through the debouncers.
// -----------------------------------------------------------------------------
module stat_event_ctrl
    import stat_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [7:0] HEALTH_INIT     = 8'hFF,
    parameter logic [7:0] DAMAGE          = 8'd1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] key_n,
    output logic [7:0] score,
    output logic [7:0] all_time,
    output logic [7:0] health,
    output logic       game_over,
    output logic       over_pulse,
    output logic [1:0] state
);

    logic       press_score;
    logic       press_damage;
    logic       press_start;

    logic [1:0] state_next;
    logic [7:0] score_next;
    logic [7:0] health_next;
    logic [7:0] all_time_next;
    logic       game_over_next;
    logic       over_pulse_next;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_score (
        .clk    (clk),
        .resetn (resetn),
        .key_n  (key_n[K_SCORE]),
        .press  (press_score)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_damage (
        .clk    (clk),
        .resetn (resetn),
        .key_n  (key_n[K_DAMAGE]),
        .press  (press_damage)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk    (clk),
        .resetn (resetn),
        .key_n  (key_n[K_START]),
        .press  (press_start)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state together with the score/health values that move with it.
    always_comb begin
        state_next  = state;
        score_next  = score;
        health_next = health;
        case (state)
            ST_IDLE: begin
                if (press_start) begin
                    state_next  = ST_PLAY;
                    score_next  = 8'd0;
                    health_next = HEALTH_INIT;
                end
            end
            ST_PLAY: begin
                // Start wins over anything arriving in the same cycle.
                if (press_start) begin
                    score_next  = 8'd0;
                    health_next = HEALTH_INIT;
                end else begin
                    // Score is applied independently of damage, so a score press
                    // that coincides with the fatal hit still counts.
                    if (press_score) begin
                        score_next = sat_inc8(score);
                    end
                    if (press_damage) begin
                        if (health > DAMAGE) begin
                            health_next = health - DAMAGE;
                        end else begin
                            health_next = 8'd0;
                            state_next  = ST_OVER;
                        end
                    end
                end
            end
            ST_OVER: begin
                if (press_start) begin
                    state_next  = ST_PLAY;
                    score_next  = 8'd0;
                    health_next = HEALTH_INIT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode, computed from the transition so the flops below line up
    // with the state register.
    always_comb begin
        game_over_next  = (state_next == ST_OVER);
        over_pulse_next = (state == ST_PLAY) && (state_next == ST_OVER);
        all_time_next   = (score_next > all_time) ? score_next : all_time;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            score      <= 8'd0;
            all_time   <= 8'd0;
            health     <= HEALTH_INIT;
            game_over  <= 1'b0;
            over_pulse <= 1'b0;
        end else begin
            score      <= score_next;
            all_time   <= all_time_next;
            health     <= health_next;
            game_over  <= game_over_next;
            over_pulse <= over_pulse_next;
        end
    end

endmodule

// File: tb/tb_stat_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stat_event_ctrl
//  Two instances share clock, reset and buttons: inst0 with HEALTH_INIT=8'hFF,
//  inst1 with HEALTH_INIT=8'h02. A game-rule model tracks both.
// -----------------------------------------------------------------------------
module tb_stat_event_ctrl;

    localparam int DB     = 4;
    localparam int HOLD   = 10;
    localparam int SETTLE = 10;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] key_n  = 3'b111;

    logic [7:0] score_a, all_a, health_a, score_b, all_b, health_b;
    logic       go_a, go_b, over_a, over_b;
    logic [1:0] state_a, state_b;

    logic [26:0] obs [2];

    int tests_run    = 0;
    int tests_failed = 0;

    // model: game-level view of each instance
    int m_state  [2];
    int m_score  [2];
    int m_health [2];
    int m_all    [2];
    int m_overs  [2] = '{0, 0};
    int h_init   [2] = '{255, 2};

    // observed event counters
    int over_cnt [2] = '{0, 0};
    int press_cnt    = 0;

    always #5 clk = ~clk;

    stat_event_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .key_n      (key_n),
        .score      (score_a),
        .all_time   (all_a),
        .health     (health_a),
        .game_over  (go_a),
        .over_pulse (over_a),
        .state      (state_a)
    );

    stat_event_ctrl #(.DEBOUNCE_CYCLES(DB), .HEALTH_INIT(8'h02)) dut_h2 (
        .clk        (clk),
        .resetn     (resetn),
        .key_n      (key_n),
        .score      (score_b),
        .all_time   (all_b),
        .health     (health_b),
        .game_over  (go_b),
        .over_pulse (over_b),
        .state      (state_b)
    );

    assign obs[0] = {state_a, go_a, all_a, health_a, score_a};
    assign obs[1] = {state_b, go_b, all_b, health_b, score_b};

    always @(negedge clk) begin
        if (dut.u_db_score.press) press_cnt++;
        if (over_a) over_cnt[0]++;
        if (over_b) over_cnt[1]++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic logic [26:0] exp_vec(input int i);
        return {2'(m_state[i]), (m_state[i] == 2), 8'(m_all[i]), 8'(m_health[i]), 8'(m_score[i])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i]  = 0;
            m_score[i]  = 0;
            m_health[i] = h_init[i];
            m_all[i]    = 0;
        end
    endtask

    task automatic model_event(input bit sc, input bit dm, input bit st);
        for (int i = 0; i < 2; i++) begin
            if (st) begin
                m_state[i]  = 1;
                m_score[i]  = 0;
                m_health[i] = h_init[i];
            end else if (m_state[i] == 1) begin
                if (sc) m_score[i] = (m_score[i] < 255) ? m_score[i] + 1 : 255;
                if (dm) begin
                    if (m_health[i] > 1) begin
                        m_health[i] = m_health[i] - 1;
                    end else begin
                        m_health[i] = 0;
                        m_state[i]  = 2;
                        m_overs[i]++;
                    end
                end
            end
            if (m_score[i] > m_all[i]) m_all[i] = m_score[i];
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the masked buttons low for `hold` cycles, releases, lets the
    // release settle. Holds of at least DB cycles register as one event.
    task automatic do_press(input logic [2:0] mask, input int hold);
        key_n = ~mask;
        repeat (hold) tick();
        key_n = 3'b111;
        repeat (SETTLE) tick();
        if (hold >= DB) model_event(mask[0], mask[1], mask[2]);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        key_n  = 3'b111;
        repeat (3) tick();
        model_reset();
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (obs[i] !== exp_vec(i)) begin
                tests_failed++;
                $display("FAIL reset_vals inst%0d: got %h required %h", i, obs[i], exp_vec(i));
            end
        end
        tests_run++;
        if ({over_a, over_b} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_over_pulse: got %b required 00", {over_a, over_b});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_idle_ignore();
        do_press(3'b001, HOLD);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (obs[i] !== exp_vec(i)) begin
                tests_failed++;
                $display("FAIL idle_score_ignored inst%0d: got %h required %h", i, obs[i], exp_vec(i));
            end
        end
        do_press(3'b100, HOLD);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (obs[i] !== exp_vec(i)) begin
                tests_failed++;
                $display("FAIL idle_start inst%0d: got %h required %h", i, obs[i], exp_vec(i));
            end
        end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = press_cnt;
        do_press(3'b001, DB - 1);
        tests_run++;
        if (press_cnt - p0 !== 0) begin
            tests_failed++;
            $display("FAIL glitch_press_count: got %0d required 0", press_cnt - p0);
        end
        tests_run++;
        if (obs[0] !== exp_vec(0)) begin
            tests_failed++;
            $display("FAIL glitch_state: got %h required %h", obs[0], exp_vec(0));
        end
    endtask

    task automatic test_latency();
        int p0;
        p0 = press_cnt;
        key_n = 3'b110;
        repeat (DB + 2) tick();
        tests_run++;
        if (score_a !== 8'(m_score[0])) begin
            tests_failed++;
            $display("FAIL latency_early: score got %h required %h at edge %0d", score_a, 8'(m_score[0]), DB + 2);
        end
        tick();
        model_event(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (score_a !== 8'(m_score[0])) begin
            tests_failed++;
            $display("FAIL latency_edge: score got %h required %h at edge %0d", score_a, 8'(m_score[0]), DB + 3);
        end
        repeat (HOLD - DB - 3) tick();
        key_n = 3'b111;
        repeat (SETTLE) tick();
        tests_run++;
        if (press_cnt - p0 !== 1) begin
            tests_failed++;
            $display("FAIL latency_one_pulse: press pulses got %0d required 1", press_cnt - p0);
        end
    endtask

    task automatic test_scores();
        do_press(3'b100, HOLD);
        repeat (5) do_press(3'b001, HOLD);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (obs[i] !== exp_vec(i)) begin
                tests_failed++;
                $display("FAIL five_scores inst%0d: got %h required %h", i, obs[i], exp_vec(i));
            end
        end
        do_press(3'b100, HOLD);
        tests_run++;
        if (obs[0] !== exp_vec(0)) begin
            tests_failed++;
            $display("FAIL restart_keeps_best: got %h required %h", obs[0], exp_vec(0));
        end
        repeat (2) do_press(3'b001, HOLD);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (obs[i] !== exp_vec(i)) begin
                tests_failed++;
                $display("FAIL two_scores inst%0d: got %h required %h", i, obs[i], exp_vec(i));
            end
        end
    endtask

    task automatic test_fatal();
        do_press(3'b010, HOLD);
        tests_run++;
        if (obs[1] !== exp_vec(1)) begin
            tests_failed++;
            $display("FAIL first_damage: got %h required %h", obs[1], exp_vec(1));
        end
        do_press(3'b011, HOLD);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (obs[i] !== exp_vec(i)) begin
                tests_failed++;
                $display("FAIL fatal_hit inst%0d: got %h required %h", i, obs[i], exp_vec(i));
            end
            tests_run++;
            if (over_cnt[i] !== m_overs[i]) begin
                tests_failed++;
                $display("FAIL over_pulse_cycles inst%0d: got %0d required %0d", i, over_cnt[i], m_overs[i]);
            end
        end
        do_press(3'b001, HOLD);
        do_press(3'b010, HOLD);
        do_press(3'b011, HOLD);
        tests_run++;
        if (obs[1] !== exp_vec(1)) begin
            tests_failed++;
            $display("FAIL over_frozen: got %h required %h", obs[1], exp_vec(1));
        end
    endtask

    task automatic test_saturation();
        do_press(3'b100, HOLD);
        repeat (254) do_press(3'b001, HOLD);
        tests_run++;
        if (obs[0] !== exp_vec(0)) begin
            tests_failed++;
            $display("FAIL preload_fe: got %h required %h", obs[0], exp_vec(0));
        end
        repeat (3) do_press(3'b001, HOLD);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (obs[i] !== exp_vec(i)) begin
                tests_failed++;
                $display("FAIL score_saturate inst%0d: got %h required %h", i, obs[i], exp_vec(i));
            end
        end
        repeat (2) do_press(3'b010, HOLD);
        do_press(3'b100, HOLD);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (obs[i] !== exp_vec(i)) begin
                tests_failed++;
                $display("FAIL start_from_over inst%0d: got %h required %h", i, obs[i], exp_vec(i));
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] mask;
        int         hold;
        for (int n = 0; n < 40; n++) begin
            mask = 3'($urandom_range(1, 7));
            if (mask[2] && ($urandom_range(0, 3) != 0)) mask[2] = 1'b0;
            if (mask == 3'b000) mask = 3'b010;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB - 1) : $urandom_range(DB, HOLD);
            do_press(mask, hold);
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (obs[i] !== exp_vec(i) || over_cnt[i] !== m_overs[i]) begin
                    tests_failed++;
                    $display("FAIL random[%0d] inst%0d mask=%b hold=%0d: got %h/%0d required %h/%0d",
                             n, i, mask, hold, obs[i], over_cnt[i], exp_vec(i), m_overs[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        int p0;
        key_n = 3'b110;
        repeat (DB) tick();
        resetn = 1'b0;
        key_n  = 3'b111;
        repeat (2) tick();
        resetn = 1'b1;
        model_reset();
        p0 = press_cnt;
        repeat (3 * DB) tick();
        tests_run++;
        if (press_cnt - p0 !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_press: got %0d pulses required 0", press_cnt - p0);
        end
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (obs[i] !== exp_vec(i)) begin
                tests_failed++;
                $display("FAIL reset_mid_vals inst%0d: got %h required %h", i, obs[i], exp_vec(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_glitch();
        test_latency();
        test_scores();
        test_fatal();
        test_saturation();
        test_random();
        test_reset_mid_debounce();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
